// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the handshaked data-memory responder.
//   state_e           : responder FSM states (IDLE, WAIT, RESP)
//   DEFAULT_BASE_ADDR : MIPS data-segment byte address mapped to word 0
//   BE_W              : number of byte lanes in a 32-bit word
// ----------------------------------------------------------------------------
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0000;
    localparam int          BE_W              = 4;

endpackage

// File: rtl/dmem_ram.sv
// ----------------------------------------------------------------------------
// dmem_ram
// DEPTH x 32-bit synchronous word array with per-byte-lane write enables and
// a registered read port. Contents are never reset.
//   clk      in   clock, all activity on the rising edge
//   rd_en_i  in   capture mem[addr_i] into the read register
//   wr_be_i  in   per-lane write enable, bit i writes bits [8i+7:8i]
//   addr_i   in   word index
//   wdata_i  in   lane-aligned write data
//   rdata_o  out  read register; holds its value while rd_en_i is low
// ----------------------------------------------------------------------------
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rd_en_i,
    input  logic [BE_W-1:0] wr_be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_be_i[i]) begin
                mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
        if (rd_en_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Target end of the CPU31 data-memory port. Accepts one load/store at a time,
// maps the byte address onto a word index relative to BASE_ADDR, waits
// WAIT_CYCLES cycles, performs a byte-lane-masked access and returns the
// response under valid/ready flow control.
//   clk        in   clock
//   rst        in   asynchronous reset, active low
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept
//   req_we     in   1 = store, 0 = load
//   req_be     in   byte-lane enables
//   req_addr   in   byte address
//   req_wdata  in   lane-aligned store data
//   rsp_valid  out  response present
//   rsp_ready  in   CPU side consumes the response
//   rsp_rdata  out  load word; 0 for stores and rejected requests
//   rsp_err    out  request rejected, memory untouched
// ----------------------------------------------------------------------------
module dmem_responder
    import dmem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [BE_W-1:0] req_be,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err
);

    localparam int AW = $clog2(DEPTH);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            reqWe_q, reqWe_d;
    logic [BE_W-1:0] reqBe_q, reqBe_d;
    logic [31:0]     reqAddr_q, reqAddr_d;
    logic [31:0]     reqWdata_q, reqWdata_d;
    logic            err_q, err_d;
    logic            loadOk_q, loadOk_d;

    logic [31:0]     offset;
    logic            addrErr;
    logic            accessNow;
    logic [31:0]     ramRdata;

    // Offset wraps for addresses below the base; that case is flagged
    // separately, so the wrapped value never reaches the array.
    // The range test is done on the byte offset at 64 bits so that
    // 4*DEPTH cannot overflow for the largest legal depth.
    assign offset  = reqAddr_q - BASE_ADDR;
    assign addrErr = (reqAddr_q < BASE_ADDR)
                  || ({32'b0, offset} >= (64'(DEPTH) * 64'd4))
                  || (reqAddr_q[1:0] != 2'b00)
                  || (reqBe_q == '0);

    assign accessNow = (state_q == WAIT) && (cnt_q == 4'd0);

    dmem_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rd_en_i (accessNow && !addrErr && !reqWe_q),
        .wr_be_i ((accessNow && !addrErr && reqWe_q) ? reqBe_q : '0),
        .addr_i  (offset[AW+1:2]),
        .wdata_i (reqWdata_q),
        .rdata_o (ramRdata)
    );

    // Next-state logic: request fields are only captured on acceptance, so
    // anything on req_* while busy is ignored. The response flags are set on
    // the access edge and then held until the handshake.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        reqWe_d    = reqWe_q;
        reqBe_d    = reqBe_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        err_d      = err_q;
        loadOk_d   = loadOk_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    reqWe_d    = req_we;
                    reqBe_d    = req_be;
                    reqAddr_d  = req_addr;
                    reqWdata_d = req_wdata;
                    cnt_d      = 4'(WAIT_CYCLES);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d    = addrErr;
                    loadOk_d = !addrErr && !reqWe_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            reqWe_q    <= 1'b0;
            reqBe_q    <= '0;
            reqAddr_q  <= '0;
            reqWdata_q <= '0;
            err_q      <= 1'b0;
            loadOk_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reqWe_q    <= reqWe_d;
            reqBe_q    <= reqBe_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            err_q      <= err_d;
            loadOk_q   <= loadOk_d;
        end
    end

    // The array read register holds between accesses, so gating it with the
    // load-success flag gives a stable word for loads and zero otherwise.
    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = loadOk_q ? ramRdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE    = 32'h1001_0000;
    localparam int          DEPTH   = 1024;
    localparam int          WAITS   = 2;
    localparam int          TIMEOUT = 200;

    logic        clk;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    // Signals of the two small latency-only instances (index 0: 0 waits,
    // index 1: 15 waits).
    logic [1:0]        sReqValid, sReqReady, sReqWe, sRspValid, sRspErr;
    logic [1:0][3:0]   sReqBe;
    logic [1:0][31:0]  sReqAddr, sReqWdata, sRspRdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit holdLow = 0;
    bit inResp  = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [31:0] mask;
        int          accCyc;
    } exp_t;

    exp_t        expQ[$];
    logic [31:0] memModel [DEPTH];
    logic [3:0]  memKnown [DEPTH];

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYCLES(0)) dutW0 (
        .clk(clk), .rst(rst),
        .req_valid(sReqValid[0]), .req_ready(sReqReady[0]), .req_we(sReqWe[0]),
        .req_be(sReqBe[0]), .req_addr(sReqAddr[0]), .req_wdata(sReqWdata[0]),
        .rsp_valid(sRspValid[0]), .rsp_ready(1'b1),
        .rsp_rdata(sRspRdata[0]), .rsp_err(sRspErr[0])
    );

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH(16), .WAIT_CYCLES(15)) dutW15 (
        .clk(clk), .rst(rst),
        .req_valid(sReqValid[1]), .req_ready(sReqReady[1]), .req_we(sReqWe[1]),
        .req_be(sReqBe[1]), .req_addr(sReqAddr[1]), .req_wdata(sReqWdata[1]),
        .rsp_valid(sRspValid[1]), .rsp_ready(1'b1),
        .rsp_rdata(sRspRdata[1]), .rsp_err(sRspErr[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer side: random back-pressure unless a test forces it low.
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = holdLow ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory as a word array with per-byte "written" flags;
    // bytes never written are not compared.
    task automatic modelAccess(input logic we, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, output exp_t e);
        longint off;
        int     idx;
        off      = longint'(addr) - longint'(BASE);
        e.err    = 1'b0;
        e.rdata  = 32'h0;
        e.mask   = 32'hFFFF_FFFF;
        e.accCyc = 0;
        if (off < 0 || off >= 4 * DEPTH || (addr % 4) != 0 || be == 4'b0000) begin
            e.err = 1'b1;
        end else begin
            idx = int'(off / 4);
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        memModel[idx][8*b +: 8] = wdata[8*b +: 8];
                        memKnown[idx][b] = 1'b1;
                    end
                end
            end else begin
                e.rdata = memModel[idx];
                for (int b = 0; b < 4; b++) begin
                    e.mask[8*b +: 8] = memKnown[idx][b] ? 8'hFF : 8'h00;
                end
            end
        end
    endtask

    // Drives one request until accepted; when track is set, the expected
    // response is queued for the monitor.
    task automatic applyStimulus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit track);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wdata;
        n = 0;
        while (!req_ready && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: req_ready=%0b, required 1", req_ready);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            req_valid = 1'b0;
            req_we    = 1'($urandom);
            req_be    = 4'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
            if (track) begin
                modelAccess(we, be, addr, wdata, e);
                e.accCyc = cyc;
                expQ.push_back(e);
            end
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || inResp) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() != 0 || inResp) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain timeout: pending=%0d, required 0", expQ.size());
        end
    endtask

    // Monitor: compares each response on its first valid cycle and checks
    // that it holds steady until consumed.
    initial begin
        exp_t        cur;
        logic [31:0] heldData;
        logic        heldErr;
        heldData = 32'h0;
        heldErr  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst && rsp_valid) begin
                if (!inResp) begin
                    inResp   = 1;
                    heldData = rsp_rdata;
                    heldErr  = rsp_err;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected response: rsp_valid=1, required 0");
                    end else begin
                        cur = expQ.pop_front();
                        checkOutput("latency", 32'(cyc - cur.accCyc), 32'(WAITS + 1));
                        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, cur.err});
                        checkOutput("rsp_rdata", rsp_rdata & cur.mask, cur.rdata & cur.mask);
                    end
                end else begin
                    checkOutput("held rdata", rsp_rdata, heldData);
                    checkOutput("held err", {31'b0, rsp_err}, {31'b0, heldErr});
                end
                if (rsp_ready) inResp = 0;
            end
        end
    end

    // Store then load on a small instance, measuring acceptance-to-valid.
    task automatic latencyCheck(input int k, input int w);
        int n;
        int acc;
        for (int op = 0; op < 2; op++) begin
            @(negedge clk);
            sReqValid[k] = 1'b1;
            sReqWe[k]    = (op == 0);
            sReqBe[k]    = 4'hF;
            sReqAddr[k]  = BASE + 32'h8;
            sReqWdata[k] = 32'h5A5A_0000 + 32'(w);
            n = 0;
            while (!sReqReady[k] && n < TIMEOUT) begin
                @(negedge clk);
                n++;
            end
            @(posedge clk);
            @(negedge clk);
            sReqValid[k] = 1'b0;
            acc = cyc;
            n = 0;
            while (!sRspValid[k] && n < TIMEOUT) begin
                @(negedge clk);
                n++;
            end
            if (!sRspValid[k]) begin
                checks++;
                errors++;
                $display("[TB] FAIL small rsp timeout: rsp_valid=0, required 1 (waits %0d)", w);
            end else begin
                checkOutput("small latency", 32'(cyc - acc), 32'(w + 1));
                checkOutput("small err", {31'b0, sRspErr[k]}, 32'h0);
                checkOutput("small rdata", sRspRdata[k], (op == 0) ? 32'h0 : 32'h5A5A_0000 + 32'(w));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [3:0]  be;
        int          r;

        for (int i = 0; i < DEPTH; i++) memKnown[i] = 4'h0;
        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_be = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        sReqValid = '0; sReqWe = '0; sReqBe = '0; sReqAddr = '0; sReqWdata = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("reset rsp_err", {31'b0, rsp_err}, 32'h0);
        rst = 1'b1;

        // Full store, partial-lane store, and readbacks.
        applyStimulus(1'b1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF, 1);
        applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, 1);
        applyStimulus(1'b1, 4'b0001, 32'h1001_0004, 32'h0000_00AA, 1);
        applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, 1);

        // Rejected requests followed by a readback of the untouched word.
        applyStimulus(1'b0, 4'hF, 32'h1000_FFFC, 32'h0, 1);
        applyStimulus(1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, 1);
        applyStimulus(1'b0, 4'hF, 32'h1001_0002, 32'h0, 1);
        applyStimulus(1'b1, 4'b0000, 32'h1001_0004, 32'h1111_1111, 1);
        applyStimulus(1'b1, 4'hF, 32'h1000_FFFC, 32'h2222_2222, 1);
        applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, 1);
        waitDrain();

        // Back-pressure: response held, new requests refused meanwhile.
        holdLow = 1;
        applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, 1);
        r = 0;
        while (!rsp_valid && r < TIMEOUT) begin
            @(negedge clk);
            r++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF;
            req_addr = 32'h1001_0004; req_wdata = 32'h0BAD_0BAD;
            checkOutput("busy req_ready", {31'b0, req_ready}, 32'h0);
            checkOutput("held rsp_valid", {31'b0, rsp_valid}, 32'h1);
        end
        @(negedge clk);
        req_valid = 1'b0;
        holdLow = 0;
        waitDrain();
        applyStimulus(1'b0, 4'hF, 32'h1001_0004, 32'h0, 1);
        waitDrain();

        // Reset during the wait states of a store drops it entirely.
        applyStimulus(1'b1, 4'hF, 32'h1001_0008, 32'hCAFE_F00D, 1);
        waitDrain();
        applyStimulus(1'b1, 4'hF, 32'h1001_0008, 32'h1234_5678, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid-reset req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("mid-reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("mid-reset rsp_rdata", rsp_rdata, 32'h0);
        checkOutput("mid-reset rsp_err", {31'b0, rsp_err}, 32'h0);
        inResp = 0;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("post-reset rsp_valid", {31'b0, rsp_valid}, 32'h0);
        end
        applyStimulus(1'b0, 4'hF, 32'h1001_0008, 32'h0, 1);
        waitDrain();

        // Latency extremes.
        latencyCheck(0, 0);
        latencyCheck(1, 15);

        // Randomised mix of legal and illegal requests.
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            addr = BASE + 32'(4 * $urandom_range(0, 15));
            case (r)
                0: addr = BASE - 32'(4 * $urandom_range(1, 4));
                1: addr = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 3));
                2: addr = addr + 32'($urandom_range(1, 3));
                3: addr = BASE + 32'(4 * (DEPTH - 1));
                default: ;
            endcase
            be = 4'($urandom_range(0, 15));
            applyStimulus(1'($urandom_range(0, 1)), be, addr, $urandom, 1);
        end
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
